// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue/write-back slice: op codes,
// instruction field positions, tag type and op classification helpers.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Default ALU latency (edges from operand sampling to O updating).
  localparam int ALU_LAT_DEFAULT = 2;
  // Default datapath width; must match the downstream ALU.
  localparam int DW_DEFAULT      = 8;

  // Instruction layout (20 bits).
  localparam int IW       = 20;
  localparam int OP_MSB   = 19;
  localparam int OP_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 14;
  localparam int RA_MSB   = 13;
  localparam int RA_LSB   = 12;
  localparam int RB_MSB   = 11;
  localparam int RB_LSB   = 10;
  localparam int ISEL_BIT = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  typedef logic [3:0] op_t;
  typedef logic [1:0] reg_idx_t;

  localparam op_t OP_ADD  = 4'b0000;
  localparam op_t OP_SUB  = 4'b0001;
  localparam op_t OP_AND  = 4'b1000;
  localparam op_t OP_OR   = 4'b1001;
  localparam op_t OP_XOR  = 4'b1010;
  localparam op_t OP_NOT  = 4'b1011;
  localparam op_t OP_SHR  = 4'b1100;
  localparam op_t OP_ROTR = 4'b1110;
  localparam op_t OP_ROTL = 4'b1111;

  // One in-flight operation: destination register plus a valid flag.
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } tag_t;

  function automatic logic is_legal_op(input op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_SHR, OP_ROTR, OP_ROTL: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic is_unary_op(input op_t op);
    case (op)
      OP_NOT, OP_SHR, OP_ROTR, OP_ROTL: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_tag_pipe.sv
// ---------------------------------------------------------------------------
// alu_tag_pipe
// Shift register of {valid, rd} tags, depth ALU_LAT+1, tracking operations
// in flight through the ALU. Stage ALU_LAT is the one being written back.
//
// Ports:
//   ck, rst      clock, asynchronous active-high clear
//   push         enter a valid tag into stage 0 this edge
//   push_rd      destination register of the pushed tag
//   pending      per-register "result still in flight" (r0 never pending)
//   last         tag in the final stage (write-back stage)
//   busy         any stage valid
//
// EXCLUDE_LAST removes the final stage from pending; used when the issue
// stage forwards O directly (ALU_BYPASS_EN build).
// ---------------------------------------------------------------------------
module alu_tag_pipe
  import alu_pkg::*;
#(
  parameter int ALU_LAT      = ALU_LAT_DEFAULT,
  parameter bit EXCLUDE_LAST = 1'b0
) (
  input  logic     ck,
  input  logic     rst,
  input  logic     push,
  input  reg_idx_t push_rd,
  output logic [3:0] pending,
  output tag_t     last,
  output logic     busy
);

  tag_t stage [ALU_LAT+1];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // shifts from its pre-edge value regardless of statement order.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= ALU_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_t'{valid: push, rd: push_rd};
      for (int i = 1; i <= ALU_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  // NOTE: outputs get defaults before the loop so no path leaves them
  // unassigned, which would infer latches.
  always_comb begin
    pending = '0;
    busy    = 1'b0;
    for (int i = 0; i <= ALU_LAT; i++) begin
      if (stage[i].valid) begin
        busy = 1'b1;
        if (!(EXCLUDE_LAST && (i == ALU_LAT))) pending[stage[i].rd] = 1'b1;
      end
    end
    // r0 is hard-wired to zero, so a write to it never creates a dependency.
    pending[0] = 1'b0;
  end

  assign last = stage[ALU_LAT];

endmodule

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
// Issue/write-back stage in front of the two-stage ALU. Accepts 20-bit
// instructions over valid/ready, reads a 4 x DW register file, drives
// registered A/B/CTR to the ALU and writes O back at fixed latency.
// Stalls on read-after-write hazards; illegal ops are consumed as NOPs.
//
// Ports:
//   ck, rst              clock, asynchronous active-high reset
//   in_valid / in_ready  instruction handshake (in_ready combinational)
//   instr[19:0]          op[19:16] rd[15:14] ra[13:12] rb[11:10]
//                        isel[8] imm[7:0]
//   A, B, CTR            registered ALU operands / op code
//   O                    ALU result
//   wb_valid/rd/data     one-cycle write-back report
//   busy                 any operation in flight
//
// Build option: define ALU_BYPASS_EN to forward O from the write-back
// stage to the operand muxes, shortening dependent spacing by one edge.
// ---------------------------------------------------------------------------
module alu_issue
  import alu_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEFAULT,
  parameter int DW      = DW_DEFAULT
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] instr,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [3:0]    CTR,
  input  logic [DW-1:0] O,
  output logic          wb_valid,
  output logic [1:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          busy
);

`ifdef ALU_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Field decode.
  op_t      op;
  reg_idx_t rd, ra, rb;
  logic     isel;
  logic [7:0] imm;
  logic     unused_instr_bit;

  assign op   = instr[OP_MSB:OP_LSB];
  assign rd   = instr[RD_MSB:RD_LSB];
  assign ra   = instr[RA_MSB:RA_LSB];
  assign rb   = instr[RB_MSB:RB_LSB];
  assign isel = instr[ISEL_BIT];
  assign imm  = instr[IMM_MSB:IMM_LSB];
  assign unused_instr_bit = instr[9];

  logic [DW-1:0] rf [4];

  logic [3:0] pending;
  tag_t       last;
  logic       legal, binary, hazard, accept, issue;
  logic [DW-1:0] a_val, b_reg, b_val;

  alu_tag_pipe #(
    .ALU_LAT      (ALU_LAT),
    .EXCLUDE_LAST (BYPASS)
  ) u_tags (
    .ck      (ck),
    .rst     (rst),
    .push    (issue),
    .push_rd (rd),
    .pending (pending),
    .last    (last),
    .busy    (busy)
  );

  always_comb begin
    legal  = is_legal_op(op);
    binary = legal && !is_unary_op(op);
    // Only binary register-register ops actually read rb; immediates and
    // unary ops never wait on it.
    hazard = pending[ra] || (binary && !isel && pending[rb]);
    in_ready = !rst && !hazard;
    accept = in_valid && in_ready;
    issue  = accept && legal;

    a_val = (ra == 2'd0) ? '0 : rf[ra];
    b_reg = (rb == 2'd0) ? '0 : rf[rb];
    // With forwarding the write-back stage is not pending, so a source
    // naming it must take O directly (the RF still holds the old value).
    if (BYPASS && last.valid && (last.rd != 2'd0)) begin
      if (last.rd == ra) a_val = O;
      if (last.rd == rb) b_reg = O;
    end
    b_val = isel ? DW'(imm) : b_reg;
  end

  // NOTE: the register file is only four words and must read as zero out of
  // reset, so it is cleared in the async-reset branch like ordinary flops
  // rather than being left uninitialised as a RAM would be.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      A        <= '0;
      B        <= '0;
      CTR      <= 4'b0000;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      wb_valid <= last.valid;
      if (last.valid) begin
        wb_rd   <= last.rd;
        wb_data <= O;
        if (last.rd != 2'd0) rf[last.rd] <= O;
      end
      // Illegal ops are consumed without touching A/B/CTR or creating a tag.
      if (issue) begin
        A   <= a_val;
        B   <= b_val;
        CTR <= op;
      end
    end
  end

endmodule
